// File: rtl/delay_chain_sched.sv
// delay_chain_sched: NCH sample-delay channels sharing one single-port RAM.
// Each channel owns a circular LEN-word region. Write requests are arbitrated
// round-robin. Every transfer writes the new sample and reads back the one
// written LEN transfers earlier on the same channel.

// Single-port RAM, read-first, registered output, contents not reset.
module SpRamRf #(
  parameter int unsigned WORDS = 64,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] mem_q [WORDS];
  logic [DW-1:0] qout_q;

  // Read-first: qout captures the old word, then the write lands.
  always_ff @(posedge clk) begin
    qout_q <= mem_q[addr];
    if (we) begin
      mem_q[addr] <= din;
    end
  end

  assign qout = qout_q;

endmodule

module delay_chain_sched #(
  parameter int unsigned DW  = 8,
  parameter int unsigned NCH = 4,
  parameter int unsigned LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    clr,
  output logic              out_valid,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic [DW-1:0]     out_data
);

  localparam int unsigned AW = $clog2(NCH*LEN);
  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned PW = $clog2(LEN);

  // Per-channel write pointer and primed flag
  logic [PW-1:0]  ptr_q [NCH];
  logic [PW-1:0]  ptr_d [NCH];
  logic [NCH-1:0] primed_q, primed_d;

  // Round-robin priority and registered output tag
  logic [CW-1:0]  pri_q, pri_d;
  logic           out_valid_q, out_valid_d;
  logic [CW-1:0]  out_ch_q, out_ch_d;

  // Arbiter results
  logic [NCH-1:0] grant_c;
  logic [CW-1:0]  gidx_c;
  logic           any_c;
  logic [CW-1:0]  idx_c;

  // RAM side
  logic [AW-1:0]  ram_addr_c;
  logic [DW-1:0]  ram_din_c;
  logic [DW-1:0]  ram_qout;

  // Round-robin: first eligible channel at or after pri_q, modulo NCH.
  always_comb begin
    grant_c = '0;
    gidx_c  = '0;
    any_c   = 1'b0;
    idx_c   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx_c = CW'((32'(pri_q) + i) % NCH);
      if (!any_c && in_valid[idx_c] && !clr[idx_c]) begin
        any_c          = 1'b1;
        grant_c[idx_c] = 1'b1;
        gidx_c         = idx_c;
      end
    end
  end

  assign in_ready   = grant_c;
  assign ram_addr_c = AW'(gidx_c) * AW'(LEN) + AW'(ptr_q[gidx_c]);
  assign ram_din_c  = in_data[32'(gidx_c)*DW +: DW];

  // Next-state: clear wins over grant; pointer wrap primes the channel.
  always_comb begin
    ptr_d       = ptr_q;
    primed_d    = primed_q;
    pri_d       = pri_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (clr[CW'(c)]) begin
        ptr_d[c]             = '0;
        primed_d[CW'(c)]     = 1'b0;
      end else if (grant_c[CW'(c)]) begin
        if (ptr_q[c] == PW'(LEN-1)) begin
          ptr_d[c]           = '0;
          primed_d[CW'(c)]   = 1'b1;
        end else begin
          ptr_d[c]           = ptr_q[c] + PW'(1);
        end
      end
    end
    if (any_c) begin
      pri_d       = (gidx_c == CW'(NCH-1)) ? '0 : gidx_c + CW'(1);
      out_valid_d = primed_q[gidx_c];
      out_ch_d    = gidx_c;
    end
  end

  // State registers, all cleared by reset (RAM contents are not).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '{default: '0};
      primed_q    <= '0;
      pri_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      primed_q    <= primed_d;
      pri_q       <= pri_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
    end
  end

  SpRamRf #(
    .WORDS (NCH*LEN),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk  (clk),
    .we   (any_c),
    .addr (ram_addr_c),
    .din  (ram_din_c),
    .qout (ram_qout)
  );

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  // Stale RAM output is masked whenever no delayed sample is present.
  assign out_data  = out_valid_q ? ram_qout : '0;

endmodule

// File: tb/tb_delay_chain_sched.sv
// Directed bench for delay_chain_sched (NCH=4, LEN=16, DW=8).
module tb_delay_chain_sched;

  localparam int unsigned DW  = 8;
  localparam int unsigned NCH = 4;
  localparam int unsigned LEN = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    clr;
  logic              out_valid;
  logic [1:0]        out_ch;
  logic [DW-1:0]     out_data;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] dat [NCH];
  int            n_s [NCH];
  int            nxt;

  typedef logic [DW-1:0] smp_q_t [$];
  smp_q_t hist [NCH];

  always #5 clk = ~clk;

  delay_chain_sched #(.DW(DW), .NCH(NCH), .LEN(LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero_out(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ch"},    32'(out_ch),    32'd0);
    chk({tag, "_data"},  32'(out_data),  32'd0);
  endtask

  // One cycle: drive, check grant, clock, then compare against the queue model.
  task automatic step(input logic [3:0] v, input logic [3:0] c,
                      input logic [3:0] rdy, input string tag);
    int      g;
    logic    exp_v;
    logic [DW-1:0] exp_d;
    in_valid = v;
    clr      = c;
    in_data  = {dat[3], dat[2], dat[1], dat[0]};
    #1;
    chk({tag, "_ready"}, 32'(in_ready), 32'(rdy));
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++) begin
      if (c[k]) hist[k].delete();
    end
    g     = 0;
    exp_v = 1'b0;
    exp_d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rdy[k]) g = k;
    end
    if (rdy != 4'b0000) begin
      hist[g].push_back(dat[g]);
      if (hist[g].size() > LEN) begin
        exp_v = 1'b1;
        exp_d = hist[g].pop_front();
      end
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(exp_v));
    if (exp_v) begin
      chk({tag, "_out_ch"},   32'(out_ch),   32'(g));
      chk({tag, "_out_data"}, 32'(out_data), 32'(exp_d));
    end else begin
      chk({tag, "_out_data0"}, 32'(out_data), 32'd0);
    end
    in_valid = '0;
    clr      = '0;
  endtask

  // All channels request; expected grant order is strictly 0,1,2,3,...
  task automatic sat(input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      for (int c = 0; c < NCH; c++) dat[c] = 8'(c*16 + n_s[c] + 1);
      step(4'b1111, 4'b0000, 4'(1 << nxt), tag);
      n_s[nxt]++;
      nxt = (nxt + 1) % NCH;
    end
  endtask

  task automatic do_reset(input string tag);
    in_valid = '0;
    clr      = '0;
    rst_n    = 1'b0;
    #1;
    check_zero_out(tag);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) hist[c].delete();
    nxt = 0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = '0;
    clr      = '0;
    in_data  = '0;
    for (int c = 0; c < NCH; c++) begin
      dat[c] = '0;
      n_s[c] = 0;
    end
    nxt = 0;

    // Reset state
    #12;
    check_zero_out("reset");
    chk("reset_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-channel fill: channel 0 streams 1..40 back to back
    for (int n = 1; n <= 40; n++) begin
      dat[0] = 8'(n);
      step(4'b0001, 4'b0000, 4'b0001, "fill");
    end
    chk("fill_last_data", 32'(out_data), 32'd24);
    step(4'b0000, 4'b0000, 4'b0000, "fill_idle");

    // Sparse traffic on channel 1 with random idle gaps
    do_reset("rst_sparse");
    for (int n = 1; n <= 40; n++) begin
      int gap;
      dat[1] = 8'(n);
      gap = int'($urandom_range(0, 5));
      for (int i = 0; i < gap; i++) step(4'b0000, 4'b0000, 4'b0000, "gap");
      step(4'b0010, 4'b0000, 4'b0010, "sparse");
    end
    chk("sparse_last_data", 32'(out_data), 32'd24);

    // All channels saturated
    do_reset("rst_sat");
    for (int c = 0; c < NCH; c++) n_s[c] = 0;
    sat(4*20, "sat");

    // Clear channel 3 while it is the priority channel and requesting
    sat(3, "preclr");
    for (int c = 0; c < NCH; c++) dat[c] = 8'(c*16 + n_s[c] + 1);
    step(4'b1111, 4'b1000, 4'b0001, "clr");
    n_s[0]++;
    nxt = 1;
    sat(4*18, "postclr");

    // Reset mid-stream, between two transfers
    for (int c = 0; c < NCH; c++) dat[c] = 8'(c*16 + n_s[c] + 1);
    in_valid = 4'b1111;
    in_data  = {dat[3], dat[2], dat[1], dat[0]};
    do_reset("rst_mid");
    check_zero_out("rst_mid_after");
    sat(4*17, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
